// File: rtl/ped_request_ctrl.sv
// ped_request_ctrl
//   Front end for the pedestrian countdown counter. Debounces the raw
//   walk-request and pause buttons, latches walk requests, drives a
//   change_state request level until the counter acknowledges with pattern,
//   abandons unacknowledged requests after a timeout, and enforces a
//   cooldown after each walk phase.
//
// Ports
//   clk          system clock (shared with the countdown counter)
//   rst          synchronous reset, active-high
//   btn_req      raw walk-request button, active-high
//   btn_pause    raw pause button, active-high; each debounced press toggles pause
//   second[3:0]  countdown value from the counter (informational only)
//   pattern      walk-figure flag from the counter, 1 = walk phase
//   change_state request level to the counter
//   pause        pause level to the counter
//   req_pending  a debounced request is latched and not yet served
//   fsm_state    current FSM state encoding (0 IDLE, 1 ARMED, 2 WALK, 3 COOLDOWN)
module ped_request_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned ACK_TIMEOUT     = 15,
  parameter int unsigned COOLDOWN_CYCLES = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_req,
  input  logic       btn_pause,
  input  logic [3:0] second,
  input  logic       pattern,
  output logic       change_state,
  output logic       pause,
  output logic       req_pending,
  output logic [1:0] fsm_state
);

  localparam int unsigned MAX_AC = (ACK_TIMEOUT > COOLDOWN_CYCLES) ? ACK_TIMEOUT : COOLDOWN_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_AC > DEBOUNCE_CYCLES) ? MAX_AC : DEBOUNCE_CYCLES;
  localparam int unsigned TW = $clog2(MAX_ALL + 1);

  localparam logic [TW-1:0] DB_LAST  = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] CD_LAST  = TW'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    WALK     = 2'd2,
    COOLDOWN = 2'd3
  } state_e;

  // Only pattern acknowledges a request; a nonzero countdown while
  // pattern is low must not move the FSM, so second is not decoded.
  logic second_unused;
  assign second_unused = ^second;

  // Index 0 = walk request button, index 1 = pause button.
  logic [1:0]    raw;
  logic [1:0]    db_lvl_q, db_lvl_d;
  logic [1:0]    db_rise_q, db_rise_d;
  logic [TW-1:0] db_cnt_q [2];
  logic [TW-1:0] db_cnt_d [2];

  state_e        state_q, state_d;
  // ARMED and COOLDOWN never overlap, so one timer serves as both the
  // acknowledge timer and the cooldown timer.
  logic [TW-1:0] tmr_q, tmr_d;
  logic          req_q, req_d;
  logic          pause_q, pause_d;

  assign raw = {btn_pause, btn_req};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      req_q       <= 1'b0;
      pause_q     <= 1'b0;
      db_lvl_q    <= '0;
      db_rise_q   <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      req_q       <= req_d;
      pause_q     <= pause_d;
      db_lvl_q    <= db_lvl_d;
      db_rise_q   <= db_rise_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
    end
  end

  // Debounce: a raw level must differ from the accepted level for
  // DEBOUNCE_CYCLES consecutive samples before it is accepted. The rising
  // edge pulse is registered, so it acts on the cycle after acceptance.
  always_comb begin
    db_lvl_d  = db_lvl_q;
    db_rise_d = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (raw[i] == db_lvl_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] >= DB_LAST) begin
        db_lvl_d[i] = raw[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + TW'(1);
      end
      db_rise_d[i] = db_lvl_d[i] & ~db_lvl_q[i];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pause_d = pause_q ^ db_rise_q[1];
    // Requests latch in every state, paused or not.
    req_d   = req_q | db_rise_q[0];

    if (!pause_q) begin
      unique case (state_q)
        IDLE: begin
          if (req_q) begin
            state_d = ARMED;
            tmr_d   = '0;
            // A press accepted on the issuing cycle is a fresh request.
            req_d   = db_rise_q[0];
          end
        end
        ARMED: begin
          if (pattern) begin
            state_d = WALK;
          end else if (tmr_q >= ACK_LAST) begin
            state_d = IDLE;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        WALK: begin
          if (!pattern) begin
            state_d = COOLDOWN;
            tmr_d   = '0;
          end
        end
        COOLDOWN: begin
          if (tmr_q >= CD_LAST) begin
            state_d = IDLE;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    change_state = (state_q == ARMED);
    pause        = pause_q;
    req_pending  = req_q;
    fsm_state    = state_q;
  end

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Directed testbench for ped_request_ctrl with default parameters
// (debounce 3, acknowledge timeout 15, cooldown 5).
// Observed vector obs = {change_state, pause, req_pending, fsm_state[1:0]}.
module tb_ped_request_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_req = 1'b0;
  logic       btn_pause = 1'b0;
  logic [3:0] second = 4'd0;
  logic       pattern = 1'b0;
  logic       change_state;
  logic       pause;
  logic       req_pending;
  logic [1:0] fsm_state;
  logic [4:0] obs;

  int total = 0;
  int bad   = 0;

  ped_request_ctrl #(
    .DEBOUNCE_CYCLES(3),
    .ACK_TIMEOUT(15),
    .COOLDOWN_CYCLES(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_req(btn_req),
    .btn_pause(btn_pause),
    .second(second),
    .pattern(pattern),
    .change_state(change_state),
    .pause(pause),
    .req_pending(req_pending),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  assign obs = {change_state, pause, req_pending, fsm_state};

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    btn_req = 1'b0; btn_pause = 1'b0; pattern = 1'b0; second = 4'd0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Press btn_req for three samples; returns right after change_state rises.
  task automatic issue_request();
    btn_req = 1'b1;
    tick(3);
    btn_req = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    btn_req = 1'b0; btn_pause = 1'b0; pattern = 1'b0; second = 4'd0;
    rst = 1'b1;
    tick(2);
    total++;
    if (obs !== 5'b00000) begin bad++; $display("FAIL reset_hold obs=%b exp=%b", obs, 5'b00000); end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      total++;
      if (obs !== 5'b00000) begin bad++; $display("FAIL reset_idle cyc=%0d obs=%b exp=%b", k, obs, 5'b00000); end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    btn_req = 1'b1;
    tick(2);
    btn_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      total++;
      if (obs !== 5'b00000) begin bad++; $display("FAIL bounce_reject cyc=%0d obs=%b exp=%b", k, obs, 5'b00000); end
    end
    btn_req = 1'b1;
    tick(3);
    btn_req = 1'b0;
    total++;
    if (obs !== 5'b00000) begin bad++; $display("FAIL bounce_third obs=%b exp=%b", obs, 5'b00000); end
    tick(1);
    total++;
    if (obs !== 5'b00100) begin bad++; $display("FAIL bounce_latch obs=%b exp=%b", obs, 5'b00100); end
    tick(1);
    total++;
    if (obs !== 5'b10001) begin bad++; $display("FAIL bounce_issue obs=%b exp=%b", obs, 5'b10001); end
  endtask

  task automatic test_handshake();
    do_reset();
    issue_request();
    total++;
    if (obs !== 5'b10001) begin bad++; $display("FAIL hs_armed obs=%b exp=%b", obs, 5'b10001); end
    // Counter counting toward walk: nonzero second must not acknowledge.
    second = 4'd5;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      total++;
      if (obs !== 5'b10001) begin bad++; $display("FAIL hs_second_hold cyc=%0d obs=%b exp=%b", k, obs, 5'b10001); end
    end
    pattern = 1'b1;
    tick(1);
    total++;
    if (obs !== 5'b00010) begin bad++; $display("FAIL hs_walk obs=%b exp=%b", obs, 5'b00010); end
    tick(2);
    total++;
    if (obs !== 5'b00010) begin bad++; $display("FAIL hs_walk_hold obs=%b exp=%b", obs, 5'b00010); end
    pattern = 1'b0;
    second = 4'd0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      total++;
      if (obs !== 5'b00011) begin bad++; $display("FAIL hs_cooldown cyc=%0d obs=%b exp=%b", k, obs, 5'b00011); end
    end
    tick(1);
    total++;
    if (obs !== 5'b00000) begin bad++; $display("FAIL hs_idle obs=%b exp=%b", obs, 5'b00000); end
  endtask

  task automatic test_timeout();
    do_reset();
    issue_request();
    total++;
    if (obs !== 5'b10001) begin bad++; $display("FAIL to_armed obs=%b exp=%b", obs, 5'b10001); end
    for (int k = 1; k < 15; k++) begin
      tick(1);
      total++;
      if (obs !== 5'b10001) begin bad++; $display("FAIL to_high cyc=%0d obs=%b exp=%b", k, obs, 5'b10001); end
    end
    tick(1);
    total++;
    if (obs !== 5'b00000) begin bad++; $display("FAIL to_expire obs=%b exp=%b", obs, 5'b00000); end
    tick(3);
    total++;
    if (obs !== 5'b00000) begin bad++; $display("FAIL to_stay_idle obs=%b exp=%b", obs, 5'b00000); end
  endtask

  task automatic test_timeout_tie();
    do_reset();
    issue_request();
    tick(14);
    total++;
    if (obs !== 5'b10001) begin bad++; $display("FAIL tie_armed obs=%b exp=%b", obs, 5'b10001); end
    pattern = 1'b1;
    tick(1);
    total++;
    if (obs !== 5'b00010) begin bad++; $display("FAIL tie_pattern_wins obs=%b exp=%b", obs, 5'b00010); end
    pattern = 1'b0;
    tick(1);
  endtask

  task automatic test_press_in_walk();
    do_reset();
    issue_request();
    pattern = 1'b1;
    tick(1);
    btn_req = 1'b1;
    tick(3);
    btn_req = 1'b0;
    tick(1);
    total++;
    if (obs !== 5'b00110) begin bad++; $display("FAIL walk_latch obs=%b exp=%b", obs, 5'b00110); end
    pattern = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      total++;
      if (obs !== 5'b00111) begin bad++; $display("FAIL walk_cooldown cyc=%0d obs=%b exp=%b", k, obs, 5'b00111); end
    end
    tick(1);
    total++;
    if (obs !== 5'b00100) begin bad++; $display("FAIL walk_idle_pending obs=%b exp=%b", obs, 5'b00100); end
    tick(1);
    total++;
    if (obs !== 5'b10001) begin bad++; $display("FAIL walk_reissue obs=%b exp=%b", obs, 5'b10001); end
  endtask

  task automatic test_pause();
    do_reset();
    issue_request();
    tick(2);
    // Pause takes effect 4 edges after the press; the timer reaches 6 on that edge.
    btn_pause = 1'b1;
    tick(4);
    btn_pause = 1'b0;
    total++;
    if (obs !== 5'b11001) begin bad++; $display("FAIL pause_on obs=%b exp=%b", obs, 5'b11001); end
    for (int k = 0; k < 10; k++) begin
      tick(1);
      total++;
      if (obs !== 5'b11001) begin bad++; $display("FAIL pause_freeze cyc=%0d obs=%b exp=%b", k, obs, 5'b11001); end
    end
    btn_pause = 1'b1;
    tick(4);
    btn_pause = 1'b0;
    total++;
    if (obs !== 5'b10001) begin bad++; $display("FAIL pause_off obs=%b exp=%b", obs, 5'b10001); end
    tick(8);
    total++;
    if (obs !== 5'b10001) begin bad++; $display("FAIL pause_resume obs=%b exp=%b", obs, 5'b10001); end
    tick(1);
    total++;
    if (obs !== 5'b00000) begin bad++; $display("FAIL pause_timeout obs=%b exp=%b", obs, 5'b00000); end
    tick(3);
    btn_pause = 1'b1;
    tick(4);
    btn_pause = 1'b0;
    total++;
    if (obs !== 5'b01000) begin bad++; $display("FAIL pause_idle_on obs=%b exp=%b", obs, 5'b01000); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    total++;
    if (obs !== 5'b00000) begin bad++; $display("FAIL pause_reset obs=%b exp=%b", obs, 5'b00000); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    btn_req = 1'b1;
    btn_pause = 1'b1;
    tick(4);
    btn_req = 1'b0;
    btn_pause = 1'b0;
    total++;
    if (obs !== 5'b01100) begin bad++; $display("FAIL simul_both obs=%b exp=%b", obs, 5'b01100); end
    tick(5);
    total++;
    if (obs !== 5'b01100) begin bad++; $display("FAIL simul_hold obs=%b exp=%b", obs, 5'b01100); end
    btn_pause = 1'b1;
    tick(4);
    btn_pause = 1'b0;
    total++;
    if (obs !== 5'b00100) begin bad++; $display("FAIL simul_unpause obs=%b exp=%b", obs, 5'b00100); end
    tick(1);
    total++;
    if (obs !== 5'b10001) begin bad++; $display("FAIL simul_issue obs=%b exp=%b", obs, 5'b10001); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    issue_request();
    pattern = 1'b1;
    tick(1);
    pattern = 1'b0;
    tick(2);
    total++;
    if (obs !== 5'b00011) begin bad++; $display("FAIL midop_cooldown obs=%b exp=%b", obs, 5'b00011); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    total++;
    if (obs !== 5'b00000) begin bad++; $display("FAIL midop_reset obs=%b exp=%b", obs, 5'b00000); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_bounce();
    test_handshake();
    test_timeout();
    test_timeout_tie();
    test_press_in_walk();
    test_pause();
    test_simultaneous();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ped_request_ctrl.md
Name: ped_request_ctrl

Overview:
- Front end for the pedestrian countdown counter. It turns raw push-button inputs into that counter's control inputs: a `change_state` level request and a `pause` level.
- It debounces the walk-request and pause buttons and holds `change_state` until the counter acknowledges by raising `pattern` (walk phase active).
- It enforces a cooldown after each walk phase so repeated presses cannot keep the crossing in walk.

Parameters:
- DEBOUNCE_CYCLES, 3: consecutive equal samples required before a raw button level is accepted.
- ACK_TIMEOUT, 15: maximum cycles `change_state` stays high without seeing `pattern`=1. On expiry the request is abandoned.
- COOLDOWN_CYCLES, 5: cycles after `pattern` falls during which new requests are latched but not issued.

Ports:
- clk  input  1  system clock, the same clock as the countdown counter.
- rst  input  1  synchronous reset, active-high.
- btn_req  input  1  raw walk-request button, active-high.
- btn_pause  input  1  raw pause button, active-high. Each debounced press toggles pause.
- second  input  4  countdown value fed back from the counter (0 = not walking, 1..10 = walk seconds).
- pattern  input  1  walk-figure flag fed back from the counter. 1 = walk phase.
- change_state  output  1  request level to the counter.
- pause  output  1  pause level to the counter.
- req_pending  output  1  a debounced request is latched and not yet served.
- fsm_state  output  2  current state encoding, for display and debug.

Behaviour:
- All registers update on the rising edge of `clk`.
- Reset is synchronous and active-high. On `rst`=1:
  - `change_state`=0, `pause`=0, `req_pending`=0.
  - FSM=IDLE (`fsm_state`=0).
  - Debounce counters = 0; debounced levels = 0; all timers = 0.
- Debounce, per button:
  - Track the raw level. A counter increments while raw differs from the debounced level and clears when raw equals it.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the raw value and the counter clears.
  - A debounced rising edge is a one-cycle internal pulse.
- Pause:
  - A debounced rising edge of `btn_pause` toggles `pause` on the following cycle.
  - While `pause`=1, the FSM holds its state and all timers freeze.
  - Request latching still operates while paused.
  - `change_state` keeps its value while paused.
- Request latch:
  - A debounced rising edge of `btn_req` sets `req_pending`. This applies in every state, including while paused.
  - `req_pending` clears only when a request is issued (on the IDLE→ARMED transition) or on reset.
- FSM states:
  - IDLE (0): `change_state`=0. If `req_pending`=1 and not paused → ARMED next cycle, clear `req_pending`, clear the ACK timer.
  - ARMED (1): `change_state`=1; the ACK timer increments each unpaused cycle.
    - If `pattern`=1 → WALK; `change_state` drops in the same transition.
    - Else if the timer reaches ACK_TIMEOUT-1 → IDLE with `change_state`=0; the request is dropped.
    - If `pattern`=1 and the timeout coincide, `pattern` wins (go to WALK).
  - WALK (2): `change_state`=0. When `pattern`=0 → COOLDOWN and clear the cooldown timer. Presses during WALK set `req_pending`.
  - COOLDOWN (3): `change_state`=0; the timer increments each unpaused cycle. At COOLDOWN_CYCLES-1 → IDLE. A pending request is then issued on the next cycle.
- `change_state` is low for at least one cycle between any two requests, so the counter's one-shot edge logic re-arms.
- Sanity check in ARMED: if `second` is nonzero while `pattern`=0 (the counter is counting down into walk), the FSM stays in ARMED; only `pattern` acknowledges.
- `rst` asserted mid-operation in any state returns all outputs to reset values on the next edge, regardless of `pause`.
- Simultaneous debounced `btn_req` and `btn_pause` edges: both take effect. The request is latched and pause toggles.
- Timer widths: ceil(log2(max(ACK_TIMEOUT, COOLDOWN_CYCLES, DEBOUNCE_CYCLES)+1)) bits, unsigned. Timers never wrap; they saturate at their terminal count.

Test Plan:
- Reset then idle: `rst`=1 for 2 cycles, then release → `change_state`=0, `pause`=0, `req_pending`=0, `fsm_state`=0 for 20 cycles with buttons low.
- Bounce rejection: `btn_req` high for 2 cycles then low → `req_pending` stays 0. Then `btn_req` high for 3 cycles → `req_pending`=1 one cycle after the 3rd sample. `change_state`=1 the following cycle.
- Normal handshake: issue a request, drive `pattern`=1 four cycles after `change_state` rises → `change_state` falls on the next edge and `fsm_state`=2. Drop `pattern` → `fsm_state`=3 for 5 cycles, then 0.
- Timeout: issue a request and keep `pattern`=0 → `change_state` high for exactly 15 cycles, then 0 with `fsm_state`=0. `req_pending` stays 0.
- Press during walk/cooldown: press `btn_req` while `fsm_state`=2 → `req_pending`=1. After the 5-cycle cooldown, `change_state` rises one cycle after entering IDLE.
- Pause freeze: in ARMED with the timer at 6, toggle pause on → `fsm_state` and the timer hold for 10 cycles and `change_state` stays 1. Toggle pause off → timeout occurs 9 cycles later. Assert `rst` while paused → `pause`=0 next edge.
